monitor_desigualdade: RTL and testbench

- Sequential consumer placed directly downstream of the 6-bit inequality comparator.
- Each cycle it may accept one comparison sample: the `diferente` flag plus the operand pair that produced it.
- It maintains a saturating total-mismatch count and a consecutive-mismatch run length.
- It captures the first mismatching operand pair, and raises a sticky alarm once the run reaches a threshold.

---
 rtl/monitor_desigualdade_pkg.sv | 20 ++
 rtl/monitor_desigualdade_contador.sv | 34 +++
 rtl/monitor_desigualdade.sv | 147 ++++++++++++++
 tb/tb_monitor_desigualdade.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/monitor_desigualdade_pkg.sv
// -----------------------------------------------------------------------------
// pacote_monitor
//   Shared definitions for the inequality monitor: FSM state encoding,
//   state width and default parameter values.
// -----------------------------------------------------------------------------
package pacote_monitor;

  localparam int ESTADO_W       = 2;
  localparam int LIMIAR_PADRAO  = 3;
  localparam int CONT_W_PADRAO  = 8;
  localparam int LARGURA_PADRAO = 6;

  // Code 3 is deliberately left out; the FSM recovers from it to OCIOSO.
  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 2'd0,
    MONITOR = 2'd1,
    ALARME  = 2'd2
  } estado_t;

endpackage

// File: rtl/monitor_desigualdade_contador.sv
// -----------------------------------------------------------------------------
// contador_saturado
//   Up-counter that saturates at all-ones instead of wrapping.
//
//   Ports:
//     clk    - clock, rising edge
//     reset  - synchronous active-high reset (q -> 0)
//     clr    - synchronous clear (q -> 0)
//     inc    - increment by one, unless already at all-ones
//     zera   - load zero; wins over inc
//     q      - counter value
// -----------------------------------------------------------------------------
module contador_saturado #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             zera,
  output logic [width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (inc && (q != {width{1'b1}})) begin
      q <= q + width'(1);
    end
  end

endmodule

// File: rtl/monitor_desigualdade.sv
// -----------------------------------------------------------------------------
// monitor_desigualdade
//   Sits after the 6-bit inequality comparator. Each valido cycle consumes one
//   sample (diferente flag + operand pair) and tracks:
//     - total_dif : saturating count of mismatching samples
//     - seq_dif   : saturating length of the current mismatch run
//     - primeiro_a/primeiro_b : operands of the first mismatch since clear
//     - alarme    : sticky flag raised when the run reaches LIMIAR
//
//   Handshake: valido is a one-sided strobe. There is no ready; every cycle
//   with valido=1 is consumed on that rising edge unless reset or limpar is
//   also high, in which case the sample is discarded.
//
//   Ports:
//     clk, reset          - clock and synchronous active-high reset
//     valido              - sample strobe
//     diferente           - comparator result (1 = operands differ)
//     a_in, b_in          - operand pair of the sample
//     limpar              - synchronous clear of counters, capture and alarm
//     total_dif, seq_dif  - counters (CONT_W bits)
//     alarme              - sticky alarm
//     captura_valida      - primeiro_a/primeiro_b hold a captured pair
//     primeiro_a/b        - first mismatching pair
//     estado              - FSM state for debug
//   All outputs are registered.
// -----------------------------------------------------------------------------
module monitor_desigualdade
  import pacote_monitor::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int LIMIAR  = LIMIAR_PADRAO,
  parameter int CONT_W  = CONT_W_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valido,
  input  logic               diferente,
  input  logic [LARGURA-1:0] a_in,
  input  logic [LARGURA-1:0] b_in,
  input  logic               limpar,
  output logic [CONT_W-1:0]  total_dif,
  output logic [CONT_W-1:0]  seq_dif,
  output logic               alarme,
  output logic               captura_valida,
  output logic [LARGURA-1:0] primeiro_a,
  output logic [LARGURA-1:0] primeiro_b,
  output logic [ESTADO_W-1:0] estado
);

  estado_t estado_q;
  estado_t estado_prox;

  logic            amostra_dif;
  logic            amostra_igual;
  logic [CONT_W:0] seq_inc;
  logic            atinge_limiar;

  assign amostra_dif   = valido && diferente;
  assign amostra_igual = valido && !diferente;

  // Threshold is checked on the incremented value with one extra bit, before
  // the counter clips it, so the compare never sees a wrapped value.
  assign seq_inc       = {1'b0, seq_dif} + (CONT_W+1)'(1);
  assign atinge_limiar = (seq_inc == (CONT_W+1)'(LIMIAR));

  // ---------------------------------------------------------------------------
  // Counters. limpar goes in as clr so it beats any same-cycle sample.
  // ---------------------------------------------------------------------------
  contador_saturado #(.width(CONT_W)) u_total (
    .clk   (clk),
    .reset (reset),
    .clr   (limpar),
    .inc   (amostra_dif),
    .zera  (1'b0),
    .q     (total_dif)
  );

  contador_saturado #(.width(CONT_W)) u_seq (
    .clk   (clk),
    .reset (reset),
    .clr   (limpar),
    .inc   (amostra_dif),
    .zera  (amostra_igual),
    .q     (seq_dif)
  );

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_prox = estado_q;
    case (estado_q)
      OCIOSO: begin
        // The first sample is processed normally, so with LIMIAR=1 a
        // first-sample mismatch goes straight to ALARME.
        if (valido) begin
          estado_prox = (amostra_dif && atinge_limiar) ? ALARME : MONITOR;
        end
      end
      MONITOR: begin
        if (amostra_dif && atinge_limiar) begin
          estado_prox = ALARME;
        end
      end
      ALARME: begin
        estado_prox = ALARME;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
    if (limpar) begin
      estado_prox = OCIOSO;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and alarm registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      alarme   <= 1'b0;
    end else begin
      estado_q <= estado_prox;
      alarme   <= (estado_prox == ALARME);
    end
  end

  assign estado = estado_q;

  // ---------------------------------------------------------------------------
  // First-mismatch capture, frozen once captura_valida is set
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || limpar) begin
      captura_valida <= 1'b0;
      primeiro_a     <= '0;
      primeiro_b     <= '0;
    end else if (amostra_dif && !captura_valida) begin
      captura_valida <= 1'b1;
      primeiro_a     <= a_in;
      primeiro_b     <= b_in;
    end
  end

endmodule

// File: tb/tb_monitor_desigualdade.sv
// -----------------------------------------------------------------------------
// tb_monitor_desigualdade
//   Directed bench. u0 uses the defaults (LIMIAR=3, CONT_W=8); u1 uses
//   CONT_W=3 for saturation; u2 shares u1's inputs with LIMIAR=1.
// -----------------------------------------------------------------------------
module tb_monitor_desigualdade;

  logic       clk;
  logic       reset;

  // u0 signals
  logic       valido, diferente, limpar;
  logic [5:0] a_in, b_in;
  logic [7:0] total_dif, seq_dif;
  logic       alarme, captura_valida;
  logic [5:0] primeiro_a, primeiro_b;
  logic [1:0] estado;

  // u1 / u2 shared inputs
  logic       valido_s, diferente_s, limpar_s;
  logic [5:0] a_s, b_s;
  logic [2:0] total_1, seq_1, total_2, seq_2;
  logic       alarme_1, cap_1, alarme_2, cap_2;
  logic [5:0] pa_1, pb_1, pa_2, pb_2;
  logic [1:0] estado_1, estado_2;

  int vectors;
  int miscompares;

  monitor_desigualdade u0 (
    .clk(clk), .reset(reset), .valido(valido), .diferente(diferente),
    .a_in(a_in), .b_in(b_in), .limpar(limpar),
    .total_dif(total_dif), .seq_dif(seq_dif), .alarme(alarme),
    .captura_valida(captura_valida), .primeiro_a(primeiro_a),
    .primeiro_b(primeiro_b), .estado(estado)
  );

  monitor_desigualdade #(.LARGURA(6), .LIMIAR(3), .CONT_W(3)) u1 (
    .clk(clk), .reset(reset), .valido(valido_s), .diferente(diferente_s),
    .a_in(a_s), .b_in(b_s), .limpar(limpar_s),
    .total_dif(total_1), .seq_dif(seq_1), .alarme(alarme_1),
    .captura_valida(cap_1), .primeiro_a(pa_1), .primeiro_b(pb_1),
    .estado(estado_1)
  );

  monitor_desigualdade #(.LARGURA(6), .LIMIAR(1), .CONT_W(3)) u2 (
    .clk(clk), .reset(reset), .valido(valido_s), .diferente(diferente_s),
    .a_in(a_s), .b_in(b_s), .limpar(limpar_s),
    .total_dif(total_2), .seq_dif(seq_2), .alarme(alarme_2),
    .captura_valida(cap_2), .primeiro_a(pa_2), .primeiro_b(pb_2),
    .estado(estado_2)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Drivers: inputs change #1 after the rising edge, outputs are read there too
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic d, input logic [5:0] a,
                      input logic [5:0] b, input logic l);
    valido = v; diferente = d; a_in = a; b_in = b; limpar = l;
    @(posedge clk);
    #1;
  endtask

  task automatic step_s(input logic v, input logic d, input logic [5:0] a,
                        input logic [5:0] b);
    valido_s = v; diferente_s = d; a_s = a; b_s = b; limpar_s = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Packed view of u0: {estado, total, seq, alarme, cap, pa, pb} = 32 bits
  function automatic logic [31:0] vista0();
    return {estado, total_dif, seq_dif, alarme, captura_valida, primeiro_a, primeiro_b};
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] exp;
    logic [21:0] exp_s;
    reset = 1'b1;
    step(1'b1, 1'b1, 6'd9, 6'd4, 1'b0);
    step(1'b1, 1'b1, 6'd9, 6'd4, 1'b0);
    reset = 1'b0;
    exp = 32'h0;
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL reset_u0 got=%h exp=%h", vista0(), exp); miscompares++;
    end
    exp_s = 22'h0;
    vectors++;
    if ({estado_1, total_1, seq_1, alarme_1, cap_1, pa_1, pb_1} !== exp_s) begin
      $display("FAIL reset_u1 got=%h exp=%h",
               {estado_1, total_1, seq_1, alarme_1, cap_1, pa_1, pb_1}, exp_s);
      miscompares++;
    end
  endtask

  task automatic test_first_sample();
    logic [31:0] exp;
    step(1'b1, 1'b0, 6'd17, 6'd17, 1'b0);
    exp = {2'd1, 8'd0, 8'd0, 1'b0, 1'b0, 6'd0, 6'd0};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL first_sample got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_capture();
    logic [31:0] exp;
    step(1'b1, 1'b1, 6'b000001, 6'b000000, 1'b0);
    exp = {2'd1, 8'd1, 8'd1, 1'b0, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL capture_first got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b1, 6'b101010, 6'b010101, 1'b0);
    exp = {2'd1, 8'd2, 8'd2, 1'b0, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL capture_frozen got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b0, 6'd3, 6'd3, 1'b0);
    exp = {2'd1, 8'd2, 8'd0, 1'b0, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL capture_run_break got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp;
    exp = {2'd1, 8'd2, 8'd0, 1'b0, 1'b1, 6'b000001, 6'b000000};
    // diferente=1 with valido=0 must be ignored
    step(1'b0, 1'b1, 6'd63, 6'd0, 1'b0);
    step(1'b0, 1'b1, 6'd62, 6'd1, 1'b0);
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL hold got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_alarm();
    logic [31:0] exp;
    step(1'b1, 1'b1, 6'd10, 6'd11, 1'b0);
    exp = {2'd1, 8'd3, 8'd1, 1'b0, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL alarm_run1 got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b1, 6'd12, 6'd13, 1'b0);
    exp = {2'd1, 8'd4, 8'd2, 1'b0, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL alarm_run2 got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b1, 6'd14, 6'd15, 1'b0);
    exp = {2'd2, 8'd5, 8'd3, 1'b1, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL alarm_run3 got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
    exp = {2'd2, 8'd5, 8'd0, 1'b1, 1'b1, 6'b000001, 6'b000000};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL alarm_sticky got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_limpar();
    logic [31:0] exp;
    step(1'b1, 1'b1, 6'd21, 6'd22, 1'b1);
    exp = 32'h0;
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL limpar_clear got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL limpar_idle_hold got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] exp;
    step(1'b1, 1'b1, 6'd3, 6'd4, 1'b0);
    step(1'b1, 1'b1, 6'd5, 6'd6, 1'b0);
    exp = {2'd1, 8'd2, 8'd2, 1'b0, 1'b1, 6'd3, 6'd4};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL midrun_before got=%h exp=%h", vista0(), exp); miscompares++;
    end
    reset = 1'b1;
    step(1'b1, 1'b1, 6'd40, 6'd41, 1'b0);
    reset = 1'b0;
    exp = 32'h0;
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL midrun_reset got=%h exp=%h", vista0(), exp); miscompares++;
    end
    step(1'b1, 1'b1, 6'd7, 6'd8, 1'b0);
    exp = {2'd1, 8'd1, 8'd1, 1'b0, 1'b1, 6'd7, 6'd8};
    vectors++;
    if (vista0() !== exp) begin
      $display("FAIL midrun_recapture got=%h exp=%h", vista0(), exp); miscompares++;
    end
  endtask

  task automatic test_saturation();
    logic [2:0]  sat;
    logic [21:0] exp1, got1;
    logic [9:0]  exp2, got2;
    for (int k = 1; k <= 10; k++) begin
      step_s(1'b1, 1'b1, 6'(k), 6'd0);
      sat  = (k > 7) ? 3'd7 : 3'(k);
      exp1 = {(k >= 3) ? 2'd2 : 2'd1, sat, sat, (k >= 3), 1'b1, 6'd1, 6'd0};
      got1 = {estado_1, total_1, seq_1, alarme_1, cap_1, pa_1, pb_1};
      vectors++;
      if (got1 !== exp1) begin
        $display("FAIL sat_u1_step%0d got=%h exp=%h", k, got1, exp1); miscompares++;
      end
      // LIMIAR=1: alarm on the very first mismatch
      exp2 = {2'd2, sat, sat, 1'b1, 1'b1};
      got2 = {estado_2, total_2, seq_2, alarme_2, cap_2};
      vectors++;
      if (got2 !== exp2) begin
        $display("FAIL lim1_u2_step%0d got=%h exp=%h", k, got2, exp2); miscompares++;
      end
    end
    step_s(1'b1, 1'b0, 6'd0, 6'd0);
    exp1 = {2'd2, 3'd7, 3'd0, 1'b1, 1'b1, 6'd1, 6'd0};
    got1 = {estado_1, total_1, seq_1, alarme_1, cap_1, pa_1, pb_1};
    vectors++;
    if (got1 !== exp1) begin
      $display("FAIL sat_u1_break got=%h exp=%h", got1, exp1); miscompares++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    valido = 1'b0; diferente = 1'b0; limpar = 1'b0; a_in = '0; b_in = '0;
    valido_s = 1'b0; diferente_s = 1'b0; limpar_s = 1'b0; a_s = '0; b_s = '0;
    test_reset();
    test_first_sample();
    test_capture();
    test_hold();
    test_alarm();
    test_limpar();
    test_reset_mid_run();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
